// File: rtl/reg_file_pkg.sv
// Shared types and constants for the register-file access sequencer.
// States, rf port encodings and default widths.
package reg_file_pkg;

  localparam int DEF_REG_IDX_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int REG_ZERO          = 0;

  localparam logic RF_OP_NONE   = 1'b0;
  localparam logic RF_OP_ACCESS = 1'b1;
  localparam logic RF_RW_READ   = 1'b0;
  localparam logic RF_RW_WRITE  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_RSP,
    ST_WR
  } state_e;

endpackage

// File: rtl/reg_access_ctrl.sv
// Serializes operand reads and writebacks onto a single-port regfile.
// Writes win over reads; x0 never touches the regfile.
module reg_access_ctrl
  import reg_file_pkg::*;
#(
  parameter int REG_IDX_WIDTH = DEF_REG_IDX_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [REG_IDX_WIDTH-1:0] rd_rs1,
  input  logic [REG_IDX_WIDTH-1:0] rd_rs2,
  output logic                     rd_rsp_valid,
  input  logic                     rd_rsp_ready,
  output logic [DATA_WIDTH-1:0]    rd_rs1_data,
  output logic [DATA_WIDTH-1:0]    rd_rs2_data,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [REG_IDX_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     rf_op,
  output logic                     rf_rw,
  output logic [REG_IDX_WIDTH-1:0] rf_reg_idx,
  output logic [DATA_WIDTH-1:0]    rf_data_w,
  input  logic [DATA_WIDTH-1:0]    rf_data_r
);

  localparam logic [REG_IDX_WIDTH-1:0] IDX0 =
    REG_IDX_WIDTH'(REG_ZERO);

  state_e                   state_q, state_d;
  logic [REG_IDX_WIDTH-1:0] rs1_q, rs1_d;
  logic [REG_IDX_WIDTH-1:0] rs2_q, rs2_d;
  logic                     op_q, op_d;
  logic                     rw_q, rw_d;
  logic [REG_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    dw_q, dw_d;
  logic [DATA_WIDTH-1:0]    d1_q, d1_d;
  logic [DATA_WIDTH-1:0]    d2_q, d2_d;

  assign wb_ready     = (state_q == ST_IDLE);
  assign rd_req_ready = (state_q == ST_IDLE) && !wb_valid;
  assign rd_rsp_valid = (state_q == ST_RSP);
  assign rd_rs1_data  = d1_q;
  assign rd_rs2_data  = d2_q;
  assign rf_op        = op_q;
  assign rf_rw        = rw_q;
  assign rf_reg_idx   = idx_q;
  assign rf_data_w    = dw_q;

  // Next-state and rf port decode; read data is captured the edge after an access
  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    op_d    = op_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    dw_d    = dw_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    unique case (state_q)
      ST_IDLE: begin
        op_d = RF_OP_NONE;
        if (wb_valid) begin
          if (wb_rd != IDX0) begin
            op_d    = RF_OP_ACCESS;
            rw_d    = RF_RW_WRITE;
            idx_d   = wb_rd;
            dw_d    = wb_data;
            state_d = ST_WR;
          end
        end else if (rd_req_valid) begin
          rs1_d = rd_rs1;
          rs2_d = rd_rs2;
          d1_d  = '0;
          d2_d  = '0;
          if (rd_rs1 != IDX0) begin
            op_d    = RF_OP_ACCESS;
            rw_d    = RF_RW_READ;
            idx_d   = rd_rs1;
            state_d = ST_RD1;
          end else if (rd_rs2 != IDX0) begin
            op_d    = RF_OP_ACCESS;
            rw_d    = RF_RW_READ;
            idx_d   = rd_rs2;
            state_d = ST_RD1;
          end else begin
            state_d = ST_RSP;
          end
        end
      end
      ST_RD1: begin
        if (rs1_q != IDX0) begin
          d1_d = rf_data_r;
          if (rs2_q == rs1_q) d2_d = rf_data_r;
        end else begin
          d2_d = rf_data_r;
        end
        if (rs1_q != IDX0 && rs2_q != IDX0 &&
            rs2_q != rs1_q) begin
          op_d    = RF_OP_ACCESS;
          rw_d    = RF_RW_READ;
          idx_d   = rs2_q;
          state_d = ST_RD2;
        end else begin
          op_d    = RF_OP_NONE;
          state_d = ST_RSP;
        end
      end
      ST_RD2: begin
        d2_d    = rf_data_r;
        op_d    = RF_OP_NONE;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        op_d = RF_OP_NONE;
        if (rd_rsp_ready) state_d = ST_IDLE;
      end
      ST_WR: begin
        op_d    = RF_OP_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        op_d    = RF_OP_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and rf port registers; reset aborts any access in flight
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= ST_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op_q    <= RF_OP_NONE;
      rw_q    <= RF_RW_READ;
      idx_q   <= '0;
      dw_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      op_q    <= op_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      dw_q    <= dw_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a negedge regfile model.
// Expected read data comes from a shadow copy kept by the bench.
module tb_reg_access_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_rs1;
  logic [AW-1:0] rd_rs2;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready;
  logic [DW-1:0] rd_rs1_data;
  logic [DW-1:0] rd_rs2_data;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          rf_op;
  logic          rf_rw;
  logic [AW-1:0] rf_reg_idx;
  logic [DW-1:0] rf_data_w;
  logic [DW-1:0] rf_data_r;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int acc0     = 0;

  logic [DW-1:0] mem   [32];
  logic [DW-1:0] model [32];
  logic [63:0]   sb    [$];

  reg_access_ctrl #(.REG_IDX_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .sys_clk      (clk),
    .sys_rst      (rst_n),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_rs1       (rd_rs1),
    .rd_rs2       (rd_rs2),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rs1_data  (rd_rs1_data),
    .rd_rs2_data  (rd_rs2_data),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .rf_op        (rf_op),
    .rf_rw        (rf_rw),
    .rf_reg_idx   (rf_reg_idx),
    .rf_data_w    (rf_data_w),
    .rf_data_r    (rf_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: samples on negedge, read data held until next read
  always @(negedge clk) begin
    if (rf_op) begin
      acc_cnt = acc_cnt + 1;
      if (rf_rw) mem[rf_reg_idx] = rf_data_w;
      else       rf_data_r = mem[rf_reg_idx];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expv(input logic [AW-1:0] r);
    return (r == '0) ? '0 : model[r];
  endfunction

  task automatic do_write(input logic [AW-1:0] rd,
                          input logic [DW-1:0] data);
    int k;
    int a0;
    wb_rd    = rd;
    wb_data  = data;
    wb_valid = 1'b1;
    #1;
    k = 0;
    while (!wb_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wb_ready", 64'(wb_ready), 64'd1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    a0 = acc_cnt;
    if (rd != '0) begin
      model[rd] = data;
      chk("wr_op", 64'(rf_op), 64'd1);
      chk("wr_rw", 64'(rf_rw), 64'd1);
      chk("wr_idx", 64'(rf_reg_idx), 64'(rd));
      chk("wr_data", 64'(rf_data_w), 64'(data));
      @(posedge clk); #1;
      chk("wr_done_op", 64'(rf_op), 64'd0);
      chk("wr_done_ready", 64'(wb_ready), 64'd1);
      chk("wr_acc", 64'(acc_cnt - a0), 64'd1);
    end else begin
      chk("x0_op", 64'(rf_op), 64'd0);
      chk("x0_ready", 64'(wb_ready), 64'd1);
      @(posedge clk); #1;
      chk("x0_acc", 64'(acc_cnt - a0), 64'd0);
    end
  endtask

  task automatic rd_issue(input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2);
    int k;
    sb.push_back({expv(rs1), expv(rs2)});
    rd_rs1       = rs1;
    rd_rs2       = rs2;
    rd_req_valid = 1'b1;
    #1;
    k = 0;
    while (!rd_req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rd_req_ready", 64'(rd_req_ready), 64'd1);
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    acc0 = acc_cnt;
  endtask

  task automatic rd_finish(input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2,
                           input int n,
                           input int hold);
    int lat;
    logic [AW-1:0] first;
    logic [63:0] e;
    first = (rs1 != '0) ? rs1 : rs2;
    lat = 0;
    while (!rd_rsp_valid && lat < 10) begin
      if (lat == 0) begin
        chk("rd1_op", 64'(rf_op), 64'd1);
        chk("rd1_rw", 64'(rf_rw), 64'd0);
        chk("rd1_idx", 64'(rf_reg_idx), 64'(first));
      end
      if (lat == 1) begin
        chk("rd2_op", 64'(rf_op), 64'd1);
        chk("rd2_idx", 64'(rf_reg_idx), 64'(rs2));
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(n));
    chk("rf_accesses", 64'(acc_cnt - acc0), 64'(n));
    chk("rsp_op", 64'(rf_op), 64'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("rs1_data", 64'(rd_rs1_data), 64'(e[63:32]));
    chk("rs2_data", 64'(rd_rs2_data), 64'(e[31:0]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(rd_rsp_valid), 64'd1);
      chk("hold_rs1", 64'(rd_rs1_data), 64'(e[63:32]));
      chk("hold_rs2", 64'(rd_rs2_data), 64'(e[31:0]));
      chk("hold_wb_ready", 64'(wb_ready), 64'd0);
    end
    rd_rsp_ready = 1'b1;
    @(posedge clk); #1;
    rd_rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rd_rsp_valid), 64'd0);
    chk("idle_wb_ready", 64'(wb_ready), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]   = '0;
      model[i] = '0;
    end
    rf_data_r    = '0;
    rst_n        = 1'b0;
    rd_req_valid = 1'b0;
    rd_rs1       = '0;
    rd_rs2       = '0;
    rd_rsp_ready = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op", 64'(rf_op), 64'd0);
    chk("rst_rw", 64'(rf_rw), 64'd0);
    chk("rst_idx", 64'(rf_reg_idx), 64'd0);
    chk("rst_dw", 64'(rf_data_w), 64'd0);
    chk("rst_valid", 64'(rd_rsp_valid), 64'd0);
    chk("rst_rs1", 64'(rd_rs1_data), 64'd0);
    chk("rst_rs2", 64'(rd_rs2_data), 64'd0);
    chk("rst_wb_ready", 64'(wb_ready), 64'd1);
    rst_n = 1'b1;

    // Abort a read while RD1 is driving the regfile
    rd_issue(5'd3, 5'd4);
    chk("abort_pre_op", 64'(rf_op), 64'd1);
    chk("abort_pre_idx", 64'(rf_reg_idx), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_op", 64'(rf_op), 64'd0);
    chk("abort_valid", 64'(rd_rsp_valid), 64'd0);
    chk("abort_idx", 64'(rf_reg_idx), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 64'(rd_rsp_valid), 64'd0);
      chk("post_rst_op", 64'(rf_op), 64'd0);
    end

    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd6, 32'h12345678);

    rd_issue(5'd5, 5'd6);
    rd_finish(5'd5, 5'd6, 2, 0);
    rd_issue(5'd0, 5'd0);
    rd_finish(5'd0, 5'd0, 0, 0);
    rd_issue(5'd0, 5'd5);
    rd_finish(5'd0, 5'd5, 1, 0);
    rd_issue(5'd6, 5'd0);
    rd_finish(5'd6, 5'd0, 1, 0);

    // Write and read requested together: the write goes first
    wb_rd        = 5'd7;
    wb_data      = 32'hA5A5A5A5;
    wb_valid     = 1'b1;
    rd_rs1       = 5'd7;
    rd_rs2       = 5'd7;
    rd_req_valid = 1'b1;
    #1;
    chk("both_rd_ready", 64'(rd_req_ready), 64'd0);
    chk("both_wb_ready", 64'(wb_ready), 64'd1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    model[7] = 32'hA5A5A5A5;
    chk("both_wr_op", 64'(rf_op), 64'd1);
    chk("both_wr_rw", 64'(rf_rw), 64'd1);
    chk("both_wr_idx", 64'(rf_reg_idx), 64'd7);
    chk("both_wr_rd_ready", 64'(rd_req_ready), 64'd0);
    rd_issue(5'd7, 5'd7);
    rd_finish(5'd7, 5'd7, 1, 0);

    // Response backpressure with a writeback stalled behind it
    rd_issue(5'd5, 5'd6);
    wb_rd    = 5'd9;
    wb_data  = 32'h09090909;
    wb_valid = 1'b1;
    rd_finish(5'd5, 5'd6, 2, 4);
    do_write(5'd9, 32'h09090909);
    rd_issue(5'd9, 5'd5);
    rd_finish(5'd9, 5'd5, 2, 0);

    // Writeback to x0 is accepted but never reaches the regfile
    do_write(5'd0, 32'hFFFFFFFF);
    rd_issue(5'd0, 5'd0);
    rd_finish(5'd0, 5'd0, 0, 0);
    rd_issue(5'd0, 5'd9);
    rd_finish(5'd0, 5'd9, 1, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
